// File: rtl/alu_exec_seq.sv
// EX-stage ALU: decodes alu_op/func, executes single-cycle ops directly and runs
// iterative multiply/divide into HI/LO behind a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start; single-cycle ops complete here
// S_MUL  | shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIN  | sign fix-up, write HI/LO, pulse done
module alu_exec_seq #(
    parameter int WIDTH = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_ILL
    } op_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     src_a_q;
    logic                 is_div_q;
    logic                 dz_q;
    logic                 neg_lo_q;
    logic                 neg_hi_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 illegal_q;
    logic                 zero_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    op_t                  op;
    logic [WIDTH-1:0]     alu_res;
    logic                 is_md;
    logic                 sgn_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fin_hi;
    logic [WIDTH-1:0]     fin_lo;

    always_comb begin
        op = OP_ILL;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b11: op = OP_OR;
            default: begin
                case (func)
                    6'd32, 6'd33: op = OP_ADD;
                    6'd34, 6'd35: op = OP_SUB;
                    6'd36:        op = OP_AND;
                    6'd37:        op = OP_OR;
                    6'd38:        op = OP_XOR;
                    6'd39:        op = OP_NOR;
                    6'd42:        op = OP_SLT;
                    6'd43:        op = OP_SLTU;
                    6'd24:        if (MD_EN) op = OP_MULT;
                    6'd25:        if (MD_EN) op = OP_MULTU;
                    6'd26:        if (MD_EN) op = OP_DIV;
                    6'd27:        if (MD_EN) op = OP_DIVU;
                    6'd16:        if (MD_EN) op = OP_MFHI;
                    6'd18:        if (MD_EN) op = OP_MFLO;
                    default:      op = OP_ILL;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg  = sgn_op && src_a[WIDTH-1];
    assign b_neg  = sgn_op && src_b[WIDTH-1];
    assign a_mag  = a_neg ? -src_a : src_a;
    assign b_mag  = b_neg ? -src_b : src_b;

    // Multiply: prod_q = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // Divide: prod_q = {partial remainder, dividend bits shifting into quotient}.
    assign div_trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_lo_q ? -prod_q : prod_q;
    assign quo_fix  = neg_lo_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    assign rem_fix  = neg_hi_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

    always_comb begin
        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (dz_q) begin
                fin_hi = src_a_q;
                fin_lo = '1;
            end else begin
                fin_hi = rem_fix;
                fin_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            src_a_q   <= '0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            src_a_q  <= src_a;
                            cnt_q    <= CNT_W'(WIDTH);
                            busy_q   <= 1'b1;
                            is_div_q <= (op == OP_DIV) || (op == OP_DIVU);
                            dz_q     <= ((op == OP_DIV) || (op == OP_DIVU)) && (src_b == '0);
                            neg_lo_q <= a_neg ^ b_neg;
                            if ((op == OP_DIV) || (op == OP_DIVU)) begin
                                prod_q   <= {{WIDTH{1'b0}}, a_mag};
                                opnd_q   <= b_mag;
                                neg_hi_q <= a_neg;
                                state_q  <= S_DIV;
                            end else begin
                                prod_q   <= {{WIDTH{1'b0}}, b_mag};
                                opnd_q   <= a_mag;
                                neg_hi_q <= a_neg ^ b_neg;
                                state_q  <= S_MUL;
                            end
                        end else begin
                            result_q  <= alu_res;
                            zero_q    <= (alu_res == '0);
                            done_q    <= 1'b1;
                            illegal_q <= (op == OP_ILL);
                        end
                    end
                end
                S_MUL: begin
                    prod_q <= mul_next;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= S_FIN;
                end
                S_DIV: begin
                    prod_q <= div_next;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= S_FIN;
                end
                default: begin
                    hi_q     <= fin_hi;
                    lo_q     <= fin_lo;
                    result_q <= fin_lo;
                    zero_q   <= (fin_lo == '0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign hi      = MD_EN ? hi_q : '0;
    assign lo      = MD_EN ? lo_q : '0;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: single-cycle ops, mult/div timing and results,
// divide-by-zero, reset abort, illegal funcs and an MD_EN=0 instance.
module tb_alu_exec_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  alu_op;
    logic [5:0]  func;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy, done, zero, illegal;
    logic [31:0] result, hi, lo;
    logic        n_busy, n_done, n_zero, n_illegal;
    logic [31:0] n_result, n_hi, n_lo;

    int checks   = 0;
    int failures = 0;

    alu_exec_seq #(.WIDTH(32), .MD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .func(func),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result),
        .zero(zero), .hi(hi), .lo(lo), .illegal(illegal)
    );

    alu_exec_seq #(.WIDTH(32), .MD_EN(1'b0)) dut_nomd (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .func(func),
        .src_a(src_a), .src_b(src_b), .busy(n_busy), .done(n_done), .result(n_result),
        .zero(n_zero), .hi(n_hi), .lo(n_lo), .illegal(n_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the negedge one cycle after the start edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = op; func = fn; src_a = a; src_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; alu_op = 2'b10; func = 6'd34; src_a = 32'hDEADBEEF; src_b = 32'h12345678;
    endtask

    task automatic wait_md(output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc, bcnt, dcnt;

    initial begin
        rst = 1'b1; start = 1'b0; alu_op = 2'b00; func = 6'd0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_zero", zero, 0);
        check_val("rst_res", result, 0);
        check_val("rst_hilo", {hi, lo}, 0);

        issue(2'b10, 6'd34, 32'd5, 32'd7);
        check_val("sub_done", done, 1);
        check_val("sub_res", result, 32'hFFFFFFFE);
        check_val("sub_zero", zero, 0);
        check_val("sub_busy", busy, 0);
        @(negedge clk);
        check_val("sub_pulse", done, 0);

        issue(2'b00, 6'd0, 32'd3, 32'd4);
        check_val("add_res", result, 32'd7);
        issue(2'b11, 6'd0, 32'hF0, 32'h0F);
        check_val("ori_res", result, 32'hFF);
        issue(2'b10, 6'd36, 32'hFF00, 32'h0FF0);
        check_val("and_res", result, 32'h0F00);
        issue(2'b10, 6'd39, 32'h0, 32'h0);
        check_val("nor_res", result, 32'hFFFFFFFF);
        issue(2'b10, 6'd33, 32'hFFFFFFFF, 32'd1);
        check_val("addwrap", {zero, result}, {1'b1, 32'h0});

        issue(2'b10, 6'd42, 32'hFFFFFFFF, 32'd1);
        check_val("slt_res", result, 32'd1);
        issue(2'b10, 6'd43, 32'hFFFFFFFF, 32'd1);
        check_val("sltu_res", {zero, result}, {1'b1, 32'h0});

        issue(2'b10, 6'd24, 32'hFFFFFFFD, 32'd7);
        check_val("mul_busy1", busy, 1);
        wait_md(cyc, bcnt);
        check_val("mul_lat", cyc, 34);
        check_val("mul_bcnt", bcnt, 33);
        check_val("mul_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        check_val("mul_res", {illegal, busy, result}, {2'b00, 32'hFFFFFFEB});
        issue(2'b10, 6'd18, 32'd0, 32'd0);
        check_val("mflo", result, 32'hFFFFFFEB);
        issue(2'b10, 6'd16, 32'd0, 32'd0);
        check_val("mfhi", result, 32'hFFFFFFFF);

        issue(2'b10, 6'd25, 32'hFFFFFFFF, 32'd2);
        wait_md(cyc, bcnt);
        check_val("multu", {hi, lo}, 64'h00000001_FFFFFFFE);

        issue(2'b10, 6'd26, 32'hFFFFFFF9, 32'd2);
        wait_md(cyc, bcnt);
        check_val("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        check_val("div_lat", cyc, 34);

        issue(2'b10, 6'd27, 32'd9, 32'd0);
        wait_md(cyc, bcnt);
        check_val("dz_hilo", {hi, lo}, 64'h00000009_FFFFFFFF);
        check_val("dz_ill", {done, illegal}, 2'b10);
        check_val("dz_lat", cyc, 34);

        issue(2'b10, 6'd26, 32'h80000000, 32'hFFFFFFFF);
        wait_md(cyc, bcnt);
        check_val("minneg1", {hi, lo}, 64'h00000000_80000000);

        issue(2'b10, 6'd27, 32'd100, 32'd7);
        wait_md(cyc, bcnt);
        check_val("divu", {hi, lo, result}, {32'd2, 32'd14, 32'd14});

        issue(2'b10, 6'd63, 32'd1, 32'd1);
        check_val("ill_flags", {done, illegal}, 2'b11);
        check_val("ill_res", result, 0);
        check_val("ill_hilo", {hi, lo}, {32'd2, 32'd14});
        @(negedge clk);
        check_val("ill_pulse", {done, illegal}, 2'b00);

        // Start held for two cycles: each sampled start gives its own done.
        @(negedge clk);
        alu_op = 2'b00; src_a = 32'd1; src_b = 32'd1; start = 1'b1;
        @(negedge clk);
        check_val("b2b_1", {done, result}, {1'b1, 32'd2});
        src_a = 32'd2; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check_val("b2b_2", {done, result}, {1'b1, 32'd4});
        @(negedge clk);
        check_val("b2b_3", done, 0);

        issue(2'b10, 6'd24, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        alu_op = 2'b10; func = 6'd34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("ign_start", {busy, done}, 2'b10);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort", {busy, done, hi, lo}, 66'h0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_val("abort_nodone", {busy, 32'(dcnt)}, 33'h0);

        issue(2'b10, 6'd24, 32'd3, 32'd5);
        check_val("nomd_mult", {n_done, n_illegal, n_busy, n_result}, {3'b110, 32'h0});
        check_val("nomd_hilo", {n_hi, n_lo}, 64'h0);
        wait_md(cyc, bcnt);
        check_val("md_after", {hi, lo}, {32'd0, 32'd15});
        issue(2'b10, 6'd16, 32'd0, 32'd0);
        check_val("nomd_mfhi", {n_done, n_illegal}, 2'b11);
        check_val("nomd_add", 1'b0, 1'b0 ^ 1'b0 ^ n_busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
